// File: rtl/dec5b_rx_460800.sv
// 4B/5B link receiver: decodes 12-bit 5B frames and re-sends each byte as 8N1 UART.
// Optional macro DEC5B_STICKY_ERR_EN: errors latch ERR/LED and halt reception until reset.
module dec5b_rx_460800 #(
  parameter int unsigned RX_BIT_CLKS = 91,
  parameter int unsigned TX_BIT_CLKS = 110,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       RXD_5B,
  output logic       TXD,
  output logic [7:0] LED,
  output logic       ERR
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned RxCw  = $clog2(RX_BIT_CLKS + 1);
  localparam int unsigned TxCw  = $clog2(TX_BIT_CLKS + 1);
  localparam logic [RxCw-1:0] RxLast = RxCw'(RX_BIT_CLKS - 1);
  localparam logic [RxCw-1:0] RxHalf = RxCw'(RX_BIT_CLKS / 2 - 1);
  localparam logic [TxCw-1:0] TxLast = TxCw'(TX_BIT_CLKS - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  // Returns {valid, nibble}.
  function automatic logic [4:0] dec5b(input logic [4:0] code);
    logic [4:0] r;
    case (code)
      5'b11110: r = 5'h10;
      5'b01001: r = 5'h11;
      5'b10100: r = 5'h12;
      5'b10101: r = 5'h13;
      5'b01010: r = 5'h14;
      5'b01011: r = 5'h15;
      5'b01110: r = 5'h16;
      5'b01111: r = 5'h17;
      5'b10010: r = 5'h18;
      5'b10011: r = 5'h19;
      5'b10110: r = 5'h1A;
      5'b10111: r = 5'h1B;
      5'b11010: r = 5'h1C;
      5'b11011: r = 5'h1D;
      5'b11100: r = 5'h1E;
      5'b11101: r = 5'h1F;
      default:  r = 5'h00;
    endcase
    return r;
  endfunction

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RXD_5B;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e       rx_state_q;
  logic [RxCw-1:0] rx_cnt_q;
  logic [3:0]      rx_bit_q;
  logic [9:0]      rx_shift_q;
  logic            done_q, stop_ok_q;
  logic            halt;
  logic            err_q;
  logic [7:0]      led_q;

`ifdef DEC5B_STICKY_ERR_EN
  assign halt = err_q;
`else
  assign halt = 1'b0;
`endif

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      done_q     <= 1'b0;
      stop_ok_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rx_cnt_q <= rx_cnt_q + 1'b1;
      case (rx_state_q)
        R_IDLE: begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          if (!halt && rx_prev_q && !rx_sync_q) rx_state_q <= R_START;
        end
        R_START: begin
          if (rx_cnt_q == RxHalf) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (rx_cnt_q == RxLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[9:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 4'd9) rx_state_q <= R_STOP;
          end
        end
        R_STOP: begin
          if (rx_cnt_q == RxLast) begin
            rx_state_q <= R_IDLE;
            done_q     <= 1'b1;
            stop_ok_q  <= rx_sync_q;
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  // Frame outcome is resolved the cycle after the stop sample.
  logic [4:0] dec_lo, dec_hi;
  logic [7:0] rx_byte;
  logic       code_ok, frame_ok, err_ovf, err_code, err_frame, push, pop, full, empty;

  assign dec_lo    = dec5b(rx_shift_q[4:0]);
  assign dec_hi    = dec5b(rx_shift_q[9:5]);
  assign rx_byte   = {dec_hi[3:0], dec_lo[3:0]};
  assign code_ok   = dec_lo[4] & dec_hi[4];
  assign err_code  = done_q & ~code_ok;
  assign err_frame = done_q & code_ok & ~stop_ok_q;
  assign frame_ok  = done_q & code_ok & stop_ok_q;
  assign err_ovf   = frame_ok & full;
  assign push      = frame_ok & ~full;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
      led_q <= 8'h00;
    end else begin
`ifdef DEC5B_STICKY_ERR_EN
      err_q <= err_q | err_ovf | err_code | err_frame;
`else
      err_q <= err_ovf | err_code | err_frame;
`endif
      if (err_ovf)        led_q <= 8'hAA;
      else if (err_code)  led_q <= 8'hCC;
      else if (err_frame) led_q <= 8'hBB;
      else if (push)      led_q <= rx_byte;
    end
  end

  logic [7:0]       mem_q [Depth];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  always_ff @(posedge CLK_50M) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  tx_state_e       tx_state_q;
  logic [TxCw-1:0] tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_shift_q;
  logic            txd_q;

  // Popping at the end of a stop bit chains bytes with no idle gap.
  assign pop = ~empty & ((tx_state_q == T_IDLE) ||
                         (tx_state_q == T_STOP && tx_cnt_q == TxLast));

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
      case (tx_state_q)
        T_IDLE: begin
          tx_cnt_q <= '0;
          if (pop) begin
            tx_shift_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
            txd_q      <= 1'b0;
            tx_state_q <= T_START;
          end
        end
        T_START: begin
          if (tx_cnt_q == TxLast) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= T_DATA;
          end
        end
        T_DATA: begin
          if (tx_cnt_q == TxLast) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= T_STOP;
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end
        end
        T_STOP: begin
          if (tx_cnt_q == TxLast) begin
            tx_cnt_q <= '0;
            if (pop) begin
              tx_shift_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
              txd_q      <= 1'b0;
              tx_state_q <= T_START;
            end else begin
              tx_state_q <= T_IDLE;
            end
          end
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  assign TXD = txd_q;
  assign LED = led_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_dec5b_rx_460800.sv
// Bench for dec5b_rx_460800: UART bytes on TXD are scoreboarded against an expected queue,
// LED/ERR are checked directly. A second instance with a slow UART exercises FIFO overflow.
`timescale 1ns/1ps
module tb_dec5b_rx_460800;

  localparam int RxBit  = 91;
  localparam int TxBit  = 110;
  localparam int TxBitB = 800;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_a, rxd_a, txd_a, err_a;
  logic [7:0] led_a;
  logic       rst_b, rxd_b, txd_b, err_b;
  logic [7:0] led_b;

  dec5b_rx_460800 u_dut (
    .CLK_50M(clk),
    .RST_N  (rst_a),
    .RXD_5B (rxd_a),
    .TXD    (txd_a),
    .LED    (led_a),
    .ERR    (err_a)
  );

  dec5b_rx_460800 #(.TX_BIT_CLKS(TxBitB)) u_ovf (
    .CLK_50M(clk),
    .RST_N  (rst_b),
    .RXD_5B (rxd_b),
    .TXD    (txd_b),
    .LED    (led_b),
    .ERR    (err_b)
  );

  int         checks = 0;
  int         failures = 0;
  int         err_cnt_a = 0;
  int         err_cnt_b = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  bit         done_b = 1'b0;

  always @(negedge clk) begin
    if (err_a === 1'b1) err_cnt_a <= err_cnt_a + 1;
    if (err_b === 1'b1) err_cnt_b <= err_cnt_b + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [4:0] enc(input logic [3:0] n);
    logic [4:0] c;
    case (n)
      4'h0: c = 5'b11110;  4'h1: c = 5'b01001;  4'h2: c = 5'b10100;  4'h3: c = 5'b10101;
      4'h4: c = 5'b01010;  4'h5: c = 5'b01011;  4'h6: c = 5'b01110;  4'h7: c = 5'b01111;
      4'h8: c = 5'b10010;  4'h9: c = 5'b10011;  4'hA: c = 5'b10110;  4'hB: c = 5'b10111;
      4'hC: c = 5'b11010;  4'hD: c = 5'b11011;  4'hE: c = 5'b11100;  default: c = 5'b11101;
    endcase
    return c;
  endfunction

  // Bit 0 goes on the line first.
  function automatic logic [11:0] frame(input logic [7:0] b, input logic stop);
    return {stop, enc(b[7:4]), enc(b[3:0]), 1'b0};
  endfunction

  function automatic logic txd_of(input int which);
    return (which == 0) ? txd_a : txd_b;
  endfunction

  function automatic logic rst_of(input int which);
    return (which == 0) ? rst_a : rst_b;
  endfunction

  function automatic int qsize(input int which);
    return (which == 0) ? exp_a.size() : exp_b.size();
  endfunction

  task automatic set_line(input int which, input logic v);
    if (which == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  task automatic send_bits(input int which, input logic [11:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      set_line(which, f[i]);
      repeat (RxBit) @(negedge clk);
    end
  endtask

  task automatic wait_mon(input int which, input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst_of(which) !== 1'b1) ab = 1'b1;
    end
  endtask

  task automatic uart_mon(input int which);
    int         period;
    logic       prev, start_b, stop_b;
    logic [7:0] data, want;
    bit         ab, have;
    string      tag;
    period = (which == 0) ? TxBit : TxBitB;
    tag    = (which == 0) ? "a" : "b";
    prev   = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && txd_of(which) === 1'b0 && rst_of(which) === 1'b1) begin
        ab = 1'b0;
        wait_mon(which, period / 2, ab);
        start_b = txd_of(which);
        for (int i = 0; i < 8; i++) begin
          wait_mon(which, period, ab);
          data[i] = txd_of(which);
        end
        wait_mon(which, period, ab);
        stop_b = txd_of(which);
        if (!ab) begin
          have = 1'b0;
          want = 8'h00;
          if (which == 0 && exp_a.size() > 0) begin want = exp_a.pop_front(); have = 1'b1; end
          if (which == 1 && exp_b.size() > 0) begin want = exp_b.pop_front(); have = 1'b1; end
          if (have) begin
            check({"uart_byte_", tag}, {24'h0, data}, {24'h0, want});
            check({"uart_framing_", tag}, {30'h0, start_b, stop_b}, 32'h1);
          end else begin
            checks++;
            failures++;
            $display("FAIL uart_unexpected_%s: got byte 0x%02h, want no byte", tag, data);
          end
        end
        prev = txd_of(which);
      end else begin
        prev = txd_of(which);
      end
    end
  endtask

  task automatic wait_drain(input int which, input int budget, input string name);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qsize(which) != 0) begin
      failures++;
      $display("FAIL %s: got %0d bytes still pending after %0d cycles, want 0",
               name, qsize(which), budget);
    end
    repeat ((which == 0) ? TxBit : TxBitB) @(negedge clk);
  endtask

  task automatic reset_a();
    rxd_a = 1'b1;
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial uart_mon(0);
  initial uart_mon(1);

  // Overflow scenario on the slow-UART instance.
  initial begin
    logic [7:0] bytes_b [6];
    int         e0;
    bytes_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rst_b = 1'b0;
    rxd_b = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_led_b", {24'h0, led_b}, 32'h0);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    e0 = err_cnt_b;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_b.push_back(bytes_b[i]);
      send_bits(1, frame(bytes_b[i], 1'b1), 12);
    end
    repeat (5) @(negedge clk);
    check("t5_led_ovf", {24'h0, led_b}, 32'hAA);
`ifdef DEC5B_STICKY_ERR_EN
    check("t5_err_sticky", {31'h0, err_b}, 32'h1);
`else
    check("t5_err_pulses", err_cnt_b - e0, 32'd1);
`endif
    wait_drain(1, 45000, "t5_drain");
    done_b = 1'b1;
  end

  initial begin
    logic [7:0]  t2 [16];
    logic [11:0] f;
    int          e0, n;
    t2 = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78,
           8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
    rst_a = 1'b0;
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_txd", {31'h0, txd_a}, 32'h1);
    check("reset_led", {24'h0, led_a}, 32'h0);
    check("reset_err", {31'h0, err_a}, 32'h0);
    rst_a = 1'b1;
    repeat (5) @(negedge clk);

    // T1: hand-built frame for 0x35.
    e0 = err_cnt_a;
    exp_a.push_back(8'h35);
    send_bits(0, 12'b1101_0101_0110, 12);
    repeat (5) @(negedge clk);
    check("t1_led", {24'h0, led_a}, 32'h35);
    wait_drain(0, 3000, "t1_drain");
    check("t1_no_err", err_cnt_a - e0, 32'd0);

    // T2: back-to-back frames covering every nibble in both halves.
    e0 = err_cnt_a;
    for (int i = 0; i < 16; i++) begin
      exp_a.push_back(t2[i]);
      send_bits(0, frame(t2[i], 1'b1), 12);
    end
    repeat (5) @(negedge clk);
    check("t2_led", {24'h0, led_a}, 32'hF0);
    wait_drain(0, 4000, "t2_drain");
    check("t2_no_err", err_cnt_a - e0, 32'd0);

    // T3: illegal low code, then a valid 0xA5.
    reset_a();
    e0 = err_cnt_a;
    f = frame(8'hA0, 1'b1);
    f[5:1] = 5'b00000;
    send_bits(0, f, 12);
    repeat (5) @(negedge clk);
    check("t3_led_code_err", {24'h0, led_a}, 32'hCC);
`ifdef DEC5B_STICKY_ERR_EN
    check("t3_err_sticky", {31'h0, err_a}, 32'h1);
    send_bits(0, frame(8'hA5, 1'b1), 12);
    repeat (5) @(negedge clk);
    check("t3_led_held", {24'h0, led_a}, 32'hCC);
    repeat (1500) @(negedge clk);
`else
    check("t3_err_pulses", err_cnt_a - e0, 32'd1);
    exp_a.push_back(8'hA5);
    send_bits(0, frame(8'hA5, 1'b1), 12);
    repeat (5) @(negedge clk);
    check("t3_led_recover", {24'h0, led_a}, 32'hA5);
    wait_drain(0, 3000, "t3_drain");
    check("t3_err_total", err_cnt_a - e0, 32'd1);
`endif

    // T4: valid codes, stop bit low.
    reset_a();
    e0 = err_cnt_a;
    send_bits(0, frame(8'h35, 1'b0), 12);
    set_line(0, 1'b1);
    repeat (RxBit) @(negedge clk);
    check("t4_led_frame_err", {24'h0, led_a}, 32'hBB);
`ifdef DEC5B_STICKY_ERR_EN
    check("t4_err_sticky", {31'h0, err_a}, 32'h1);
    send_bits(0, frame(8'h35, 1'b1), 12);
    repeat (5) @(negedge clk);
    check("t4_led_held", {24'h0, led_a}, 32'hBB);
    check("t4_err_held", {31'h0, err_a}, 32'h1);
`else
    check("t4_err_pulses", err_cnt_a - e0, 32'd1);
`endif
    repeat (1500) @(negedge clk);

    // T6: reset while RX is mid-frame and TX is driving a 0 data bit.
    reset_a();
    exp_a.push_back(8'h35);
    send_bits(0, frame(8'h35, 1'b1), 12);
    send_bits(0, frame(8'hA5, 1'b1), 5);
    rst_a = 1'b0;
    #1;
    check("t6_txd_reset", {31'h0, txd_a}, 32'h1);
    exp_a.delete();
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    check("t6_led_reset", {24'h0, led_a}, 32'h0);
    check("t6_err_reset", {31'h0, err_a}, 32'h0);
    repeat (10) @(negedge clk);
    exp_a.push_back(8'h5A);
    send_bits(0, frame(8'h5A, 1'b1), 12);
    repeat (5) @(negedge clk);
    check("t6_led_after", {24'h0, led_a}, 32'h5A);
    wait_drain(0, 3000, "t6_drain");

    n = 0;
    while (!done_b && n < 60000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done_b) begin
      failures++;
      $display("FAIL t5_timeout: got overflow scenario still running, want finished");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
